// File: rtl/game_sequencer.sv
// Game flow controller: leaderboard -> select -> get-ready -> play -> win/lost -> leaderboard.
// Also latches the difficulty limits and the finishing score.
module game_sequencer #(
  parameter int TICK_DIV       = 100_000_000,
  parameter int GET_READY_TIME = 5,
  parameter int DELAY_TIME     = 3,
  parameter int EASY_LIMIT     = 7,
  parameter int MED_LIMIT      = 5,
  parameter int HARD_LIMIT     = 3
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       sel_done,
  input  logic [1:0] selection,
  input  logic       win,
  input  logic [3:0] min_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] sec_1s,
  output logic [2:0] screen_sel,
  output logic       game_clk_reset,
  output logic       sel_reset,
  output logic [3:0] ready_sec,
  output logic [3:0] lost_min,
  output logic [3:0] critical_min,
  output logic [3:0] warn_min,
  output logic [9:0] score,
  output logic       score_valid
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    LEADER = 3'd0,
    SELECT = 3'd1,
    READY  = 3'd2,
    PLAY   = 3'd3,
    WIN    = 3'd4,
    LOST   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    hold_cnt;
  logic [3:0]    limit_sel;
  logic [7:0]    elapsed;
  logic [13:0]   total;
  logic [9:0]    score_sat;

  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign elapsed   = ({4'd0, min_10s} * 8'd10) + {4'd0, min_1s};
  assign total     = ({6'd0, elapsed} * 14'd60) + ({10'd0, sec_10s} * 14'd10) + {10'd0, sec_1s};
  assign score_sat = (total > 14'd1023) ? 10'd1023 : total[9:0];

  always_comb begin
    case (selection)
      2'd1:    limit_sel = 4'(MED_LIMIT);
      2'd2:    limit_sel = 4'(HARD_LIMIT);
      default: limit_sel = 4'(EASY_LIMIT);
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) state <= LEADER;
    else       state <= state_nxt;
  end

  // Win is tested before the time limit so a simultaneous finish counts as a win.
  always_comb begin
    state_nxt = state;
    case (state)
      LEADER:   if (start) state_nxt = SELECT;
      SELECT:   if (sel_done) state_nxt = READY;
      READY:    if (tick && ready_sec <= 4'd1) state_nxt = PLAY;
      PLAY: begin
        if (win)                          state_nxt = WIN;
        else if (elapsed >= {4'd0, lost_min}) state_nxt = LOST;
      end
      WIN, LOST: if (tick && hold_cnt <= 4'd1) state_nxt = LEADER;
      default:  state_nxt = LEADER;
    endcase
  end

  always_comb begin
    screen_sel     = state;
    game_clk_reset = (state != PLAY);
    sel_reset      = (state != SELECT);
  end

  // Divider restarts on every state change so each state sees a full first second.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tick_cnt     <= '0;
      ready_sec    <= 4'd0;
      hold_cnt     <= 4'd0;
      lost_min     <= 4'd7;
      critical_min <= 4'd6;
      warn_min     <= 4'd5;
      score        <= 10'd0;
      score_valid  <= 1'b0;
    end else begin
      score_valid <= 1'b0;

      if (state_nxt != state || tick) tick_cnt <= '0;
      else                            tick_cnt <= tick_cnt + 1'b1;

      if (state == SELECT && sel_done) begin
        lost_min     <= limit_sel;
        critical_min <= limit_sel - 4'd1;
        warn_min     <= limit_sel - 4'd2;
        ready_sec    <= 4'(GET_READY_TIME);
      end else if (state == READY && tick && ready_sec != 4'd0) begin
        ready_sec <= ready_sec - 4'd1;
      end

      if (state == PLAY && win) begin
        score       <= score_sat;
        score_valid <= 1'b1;
      end

      if ((state_nxt == WIN || state_nxt == LOST) && state_nxt != state)
        hold_cnt <= 4'(DELAY_TIME);
      else if ((state == WIN || state == LOST) && tick && hold_cnt != 4'd0)
        hold_cnt <= hold_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus pushes expected screen changes,
// ready_sec values and scores; a negedge monitor pops and compares them.
module tb_game_sequencer;

  logic       clk_100MHz = 1'b0;
  logic       reset, start, sel_done, win;
  logic [1:0] selection;
  logic [3:0] min_10s, min_1s, sec_10s, sec_1s;
  logic [2:0] screen_sel;
  logic       game_clk_reset, sel_reset, score_valid;
  logic [3:0] ready_sec, lost_min, critical_min, warn_min;
  logic [9:0] score;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] scr;
    int         dwell;
    logic [3:0] lost, crit, warn;
    logic [9:0] score;
    logic       gcr, sr;
  } exp_t;

  exp_t       scr_q[$];
  logic [3:0] rs_q[$];
  logic [9:0] score_q[$];

  logic [3:0] m_lost  = 4'd7;
  logic [3:0] m_crit  = 4'd6;
  logic [3:0] m_warn  = 4'd5;
  logic [9:0] m_score = 10'd0;

  game_sequencer #(
    .TICK_DIV(4), .GET_READY_TIME(5), .DELAY_TIME(3)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .start(start), .sel_done(sel_done),
    .selection(selection), .win(win), .min_10s(min_10s), .min_1s(min_1s),
    .sec_10s(sec_10s), .sec_1s(sec_1s), .screen_sel(screen_sel),
    .game_clk_reset(game_clk_reset), .sel_reset(sel_reset), .ready_sec(ready_sec),
    .lost_min(lost_min), .critical_min(critical_min), .warn_min(warn_min),
    .score(score), .score_valid(score_valid)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] s, input int d);
    exp_t e;
    e.scr = s; e.dwell = d;
    e.lost = m_lost; e.crit = m_crit; e.warn = m_warn; e.score = m_score;
    e.gcr = (s != 3'd3); e.sr = (s != 3'd1);
    scr_q.push_back(e);
  endtask

  task automatic set_limits(input logic [3:0] l);
    m_lost = l; m_crit = l - 4'd1; m_warn = l - 4'd2;
  endtask

  task automatic push_countdown();
    for (int i = 5; i >= 0; i--) rs_q.push_back(4'(i));
  endtask

  task automatic wait_screen(input logic [2:0] s, input int budget);
    int n = 0;
    while (screen_sel !== s && n < budget) begin
      step();
      n++;
    end
    if (screen_sel !== s) begin
      checks++;
      failures++;
      $display("FAIL wait_screen actual=%0d expected=%0d (timeout)", screen_sel, s);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_screen", 16'(screen_sel), 16'd0);
    chk("rst_gcr", 16'(game_clk_reset), 16'd1);
    chk("rst_sel_reset", 16'(sel_reset), 16'd1);
    chk("rst_ready_sec", 16'(ready_sec), 16'd0);
    chk("rst_lost", 16'(lost_min), 16'd7);
    chk("rst_crit", 16'(critical_min), 16'd6);
    chk("rst_warn", 16'(warn_min), 16'd5);
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_score_valid", 16'(score_valid), 16'd0);
  endtask

  task automatic start_select(input logic [1:0] sel, input logic [3:0] lim);
    selection = sel;
    push_exp(3'd1, -1);
    start = 1'b1; step(); start = 1'b0;
    step();
    set_limits(lim);
    push_exp(3'd2, -1);
    sel_done = 1'b1; step(); sel_done = 1'b0;
  endtask

  // Monitor
  initial begin
    logic [2:0] prev_scr = 3'd0;
    logic [3:0] prev_rs  = 4'd0;
    logic       prev_sv  = 1'b0;
    int cyc = 0, last_chg = 0;
    exp_t e;
    forever begin
      @(negedge clk_100MHz);
      cyc++;
      if (screen_sel !== prev_scr) begin
        if (scr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_screen actual=%0d expected=none", screen_sel);
        end else begin
          e = scr_q.pop_front();
          chk("screen_sel", 16'(screen_sel), 16'(e.scr));
          chk("lost_min", 16'(lost_min), 16'(e.lost));
          chk("critical_min", 16'(critical_min), 16'(e.crit));
          chk("warn_min", 16'(warn_min), 16'(e.warn));
          chk("score", 16'(score), 16'(e.score));
          chk("game_clk_reset", 16'(game_clk_reset), 16'(e.gcr));
          chk("sel_reset", 16'(sel_reset), 16'(e.sr));
          if (e.dwell >= 0) chk("dwell", 16'(cyc - last_chg), 16'(e.dwell));
        end
        last_chg = cyc;
        prev_scr = screen_sel;
      end
      if (ready_sec !== prev_rs) begin
        if (rs_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready_sec actual=%0d expected=none", ready_sec);
        end else begin
          chk("ready_sec", 16'(ready_sec), 16'(rs_q.pop_front()));
        end
        prev_rs = ready_sec;
      end
      if (score_valid === 1'b1) begin
        chk("score_valid_width", 16'(prev_sv), 16'd0);
        if (score_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_score_valid actual=%0d expected=none", score);
        end else begin
          chk("valid_score", 16'(score), 16'(score_q.pop_front()));
        end
      end
      prev_sv = score_valid;
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; start = 1'b0; sel_done = 1'b0; win = 1'b0; selection = 2'd0;
    min_10s = 4'd0; min_1s = 4'd0; sec_10s = 4'd0; sec_1s = 4'd0;
    step(); step();
    check_reset_vals();
    reset = 1'b0;
    step();

    // Hard: countdown, then win at 02:37
    start_select(2'd2, 4'd3);
    push_countdown();
    push_exp(3'd3, 20);
    wait_screen(3'd3, 40);
    min_10s = 4'd0; min_1s = 4'd2; sec_10s = 4'd3; sec_1s = 4'd7;
    m_score = 10'd157;
    push_exp(3'd4, -1);
    score_q.push_back(10'd157);
    win = 1'b1; step(); win = 1'b0;
    push_exp(3'd0, 12);
    wait_screen(3'd0, 40);
    min_1s = 4'd0; sec_10s = 4'd0; sec_1s = 4'd0;

    // Medium: 5 minutes reached without win -> LOST one cycle after PLAY entry
    start_select(2'd1, 4'd5);
    min_1s = 4'd5;
    push_countdown();
    push_exp(3'd3, 20);
    push_exp(3'd5, 1);
    push_exp(3'd0, 12);
    wait_screen(3'd5, 60);
    wait_screen(3'd0, 40);
    min_1s = 4'd0;

    // Hard: win and limit together -> WIN with 03:00
    start_select(2'd2, 4'd3);
    min_1s = 4'd3; win = 1'b1;
    push_countdown();
    push_exp(3'd3, 20);
    m_score = 10'd180;
    push_exp(3'd4, 1);
    score_q.push_back(10'd180);
    push_exp(3'd0, 12);
    wait_screen(3'd4, 60);
    wait_screen(3'd0, 40);
    win = 1'b0; min_1s = 4'd0;

    // Selection 3 behaves as easy; 99:59 saturates the score
    start_select(2'd3, 4'd7);
    min_10s = 4'd9; min_1s = 4'd9; sec_10s = 4'd5; sec_1s = 4'd9; win = 1'b1;
    push_countdown();
    push_exp(3'd3, 20);
    m_score = 10'd1023;
    push_exp(3'd4, 1);
    score_q.push_back(10'd1023);
    push_exp(3'd0, 12);
    wait_screen(3'd4, 60);
    wait_screen(3'd0, 40);
    win = 1'b0; min_10s = 4'd0; min_1s = 4'd0; sec_10s = 4'd0; sec_1s = 4'd0;

    // Reset in the middle of READY after one countdown tick
    start_select(2'd1, 4'd5);
    rs_q.push_back(4'd5); rs_q.push_back(4'd4); rs_q.push_back(4'd0);
    wait_screen(3'd2, 10);
    repeat (6) step();
    set_limits(4'd7);
    m_score = 10'd0;
    push_exp(3'd0, -1);
    reset = 1'b1; step(); reset = 1'b0;
    check_reset_vals();

    // Reset together with start: start must be ignored
    step();
    reset = 1'b1; start = 1'b1; step(); reset = 1'b0; start = 1'b0;
    check_reset_vals();
    repeat (3) step();
    chk("start_ignored_screen", 16'(screen_sel), 16'd0);

    repeat (2) step();
    chk("screen_q_empty", 16'(scr_q.size()), 16'd0);
    chk("ready_q_empty", 16'(rs_q.size()), 16'd0);
    chk("score_q_empty", 16'(score_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clk_100MHz cycles per 1 s tick.
REQ-002 Parameter GET_READY_TIME, default 5, get-ready countdown seconds (1..15).
REQ-003 Parameter DELAY_TIME, default 3, win/lost screen hold seconds (1..15).
REQ-004 Parameters EASY_LIMIT/MED_LIMIT/HARD_LIMIT, defaults 7/5/3, play time limit in minutes.
REQ-005 clk_100MHz  in  1  system clock; one clock domain; reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle start request from the debounced button.
REQ-008 sel_done  in  1  difficulty selector done, level.
REQ-009 selection  in  2  difficulty: 0 easy, 1 medium, 2 hard, 3 treated as easy.
REQ-010 win  in  1  win indication from the track, level.
REQ-011 min_10s, min_1s, sec_10s, sec_1s  in  4 each  BCD game clock digits.
REQ-012 screen_sel  out  3  0 leaderboard, 1 select, 2 ready, 3 play, 4 win, 5 lost.
REQ-013 game_clk_reset  out  1  holds the game clock in reset when high.
REQ-014 sel_reset  out  1  holds the difficulty selector in reset when high.
REQ-015 ready_sec  out  4  remaining get-ready seconds.
REQ-016 lost_min, critical_min, warn_min  out  4 each  latched limit, limit-1, limit-2.
REQ-017 score  out  10  latched finishing time in seconds.
REQ-018 score_valid  out  1  one-cycle pulse when score updates.

Function
REQ-019 FSM states LEADER, SELECT, READY, PLAY, WIN, LOST; screen_sel equals the state code in REQ-012, registered.
REQ-020 Tick divider counts 0..TICK_DIV-1, pulses tick on the terminal count, and clears on every state entry, so the first tick comes TICK_DIV cycles after entry.
REQ-021 LEADER: sel_reset=1, game_clk_reset=1; start=1 -> SELECT next cycle; start ignored in all other states.
REQ-022 SELECT: sel_reset=0; sel_done=1 -> latch limits per selection, load ready_sec=GET_READY_TIME, go to READY.
REQ-023 READY: each tick decrements ready_sec; the tick that takes ready_sec from 1 to 0 moves to PLAY in the same cycle.
REQ-024 game_clk_reset=0 only in PLAY; 1 in every other state.
REQ-025 PLAY: elapsed = min_10s*10+min_1s; win=1 -> WIN; else elapsed >= lost_min -> LOST.
REQ-026 PLAY: if win=1 and the limit are both reached in the same cycle, win has priority.
REQ-027 On the PLAY->WIN transition, score is set to (min_10s*10+min_1s)*60+sec_10s*10+sec_1s, saturated at 1023, and score_valid pulses for exactly one cycle.
REQ-028 score is unchanged on the LOST path; score_valid never asserts outside the PLAY->WIN transition.
REQ-029 WIN/LOST: hold counter loads DELAY_TIME on entry and decrements each tick; at 0 -> LEADER.
REQ-030 sel_reset=1 in READY, PLAY, WIN and LOST; sel_done is ignored outside SELECT.
REQ-031 Limits remain latched until the next SELECT exit; critical_min=limit-1, warn_min=limit-2.

Reset
REQ-032 reset=1 at any clock edge, in any state, forces the following next cycle:
- state LEADER, screen_sel=0
- game_clk_reset=1, sel_reset=1
- ready_sec=0, hold counter 0, tick divider 0
- lost/critical/warn=7/6/5, score=0, score_valid=0
REQ-033 reset has priority over all inputs, including a simultaneous start, win or tick.

Verification (TICK_DIV=4, GET_READY_TIME=5, DELAY_TIME=3)
REQ-034 Bench SHALL cover: after reset, pulse start, sel_done with selection=2:
- response: screen_sel 0->1->2
- lost/critical/warn=3/2/1
- ready_sec 5..1, then PLAY 20 cycles after READY entry
REQ-035 Bench SHALL cover: PLAY with digits 0,2,3,7, then win=1:
- response: WIN, score=157, score_valid high 1 cycle
- LEADER 12 cycles later
REQ-036 Bench SHALL cover: PLAY with selection=1 and min_1s=5, win=0:
- response: LOST next cycle, score unchanged, game_clk_reset=1
REQ-037 Bench SHALL cover: win=1 in the same cycle min_1s reaches lost_min:
- response: WIN, not LOST
REQ-038 Bench SHALL cover: selection=3 -> limits 7/6/5; digits 9,9,5,9 on win -> score=1023 (saturated).
REQ-039 Bench SHALL cover: reset asserted mid-READY, and separately reset together with start:
- response: LEADER, all REQ-032 values, start ignored.
